cascade_compare_ctrl: RTL and testbench

CASCADE_COMPARE_CTRL -- requirements
Module: cascade_compare_ctrl

---
 rtl/cmp_pkg.sv | 16 +
 rtl/comparator3.sv | 32 +++
 rtl/cascade_compare_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cascade_compare_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared widths and FSM encoding for the serial slice comparator.
package cmp_pkg;

   localparam int unsigned CHUNK_W  = 3;
   localparam int unsigned N_CHUNKS = 4;
   localparam int unsigned OP_W     = CHUNK_W * N_CHUNKS;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned CNT_W    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/comparator3.sv
// 3-bit cascadable magnitude comparator: an equal slice passes l/e/g through,
// an unequal slice reports its own ordering.
module comparator3 (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       l_in,
   input  logic       e_in,
   input  logic       g_in,
   output logic       l_out,
   output logic       e_out,
   output logic       g_out
);

   logic [2:0] bit_eq;
   logic       slice_gt;
   logic       slice_lt;
   logic       slice_eq;

   assign bit_eq   = ~(a ^ b);
   assign slice_gt = (a[2] & ~b[2])
                   | (bit_eq[2] & a[1] & ~b[1])
                   | (bit_eq[2] & bit_eq[1] & a[0] & ~b[0]);
   assign slice_lt = (~a[2] & b[2])
                   | (bit_eq[2] & ~a[1] & b[1])
                   | (bit_eq[2] & bit_eq[1] & ~a[0] & b[0]);
   assign slice_eq = &bit_eq;

   assign l_out = slice_lt | (slice_eq & l_in);
   assign g_out = slice_gt | (slice_eq & g_in);
   assign e_out = slice_eq & e_in;

endmodule

// File: rtl/cascade_compare_ctrl.sv
// Serial MSB-first comparison of two 12-bit operands, one 3-bit slice per
// cycle, with early exit on the first unequal slice.
module cascade_compare_ctrl
   import cmp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [11:0] a,
   input  logic [11:0] b,
   output logic        busy,
   output logic        done,
   output logic        lt,
   output logic        eq,
   output logic        gt,
   output logic [2:0]  chunks
);

   state_t             state_q, state_d;
   logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fl_q, fl_d, fe_q, fe_d, fg_q, fg_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [CNT_W-1:0]   chunks_q, chunks_d;

   logic [CHUNK_W-1:0] sl_a, sl_b;
   logic               c_l, c_e, c_g;

   always_comb begin
      sl_a = '0;
      sl_b = '0;
      case (idx_q)
         2'd3: begin sl_a = a_q[3*CHUNK_W +: CHUNK_W]; sl_b = b_q[3*CHUNK_W +: CHUNK_W]; end
         2'd2: begin sl_a = a_q[2*CHUNK_W +: CHUNK_W]; sl_b = b_q[2*CHUNK_W +: CHUNK_W]; end
         2'd1: begin sl_a = a_q[1*CHUNK_W +: CHUNK_W]; sl_b = b_q[1*CHUNK_W +: CHUNK_W]; end
         default: begin sl_a = a_q[0 +: CHUNK_W]; sl_b = b_q[0 +: CHUNK_W]; end
      endcase
   end

   comparator3 u_cmp (
      .a     (sl_a),
      .b     (sl_b),
      .l_in  (fl_q),
      .e_in  (fe_q),
      .g_in  (fg_q),
      .l_out (c_l),
      .e_out (c_e),
      .g_out (c_g)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      fl_d     = fl_q;
      fe_d     = fe_q;
      fg_d     = fg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      lt_d     = lt_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      chunks_d = chunks_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               idx_d    = 2'd3;
               cnt_d    = '0;
               fl_d     = 1'b0;
               fe_d     = 1'b1;
               fg_d     = 1'b0;
               lt_d     = 1'b0;
               eq_d     = 1'b0;
               gt_d     = 1'b0;
               chunks_d = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               fl_d  = c_l;
               fe_d  = c_e;
               fg_d  = c_g;
               cnt_d = cnt_q + 3'd1;
               if (!c_e || idx_q == '0) begin
                  // Results load alongside the flags so they are valid in the done cycle.
                  lt_d     = c_l;
                  eq_d     = c_e;
                  gt_d     = c_g;
                  chunks_d = cnt_q + 3'd1;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end else begin
                  idx_d = idx_q - 2'd1;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         fl_q     <= 1'b0;
         fe_q     <= 1'b0;
         fg_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         chunks_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         fl_q     <= fl_d;
         fe_q     <= fe_d;
         fg_q     <= fg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         gt_q     <= gt_d;
         chunks_q <= chunks_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign lt     = lt_q;
   assign eq     = eq_q;
   assign gt     = gt_q;
   assign chunks = chunks_q;

endmodule

// File: tb/tb_cascade_compare_ctrl.sv
// Directed bench for cascade_compare_ctrl with hand-computed expectations.
module tb_cascade_compare_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [11:0] a;
   logic [11:0] b;
   logic        busy;
   logic        done;
   logic        lt;
   logic        eq;
   logic        gt;
   logic [2:0]  chunks;

   int unsigned errors = 0;
   int unsigned checks = 0;

   cascade_compare_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .abort  (abort),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .lt     (lt),
      .eq     (eq),
      .gt     (gt),
      .chunks (chunks)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // busy, done, lt, eq, gt, chunks in one go
   task automatic chk_all(input string tag, input logic eb, input logic ed, input logic el,
                          input logic ee, input logic eg, input logic [2:0] ec);
      chk({tag, ".busy"},   {11'd0, busy}, {11'd0, eb});
      chk({tag, ".done"},   {11'd0, done}, {11'd0, ed});
      chk({tag, ".lt"},     {11'd0, lt},   {11'd0, el});
      chk({tag, ".eq"},     {11'd0, eq},   {11'd0, ee});
      chk({tag, ".gt"},     {11'd0, gt},   {11'd0, eg});
      chk({tag, ".chunks"}, {9'd0, chunks}, {9'd0, ec});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      a     = '0;
      b     = '0;
      #2;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      // equal operands: start presented as reset releases, accepted on first edge
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      a     = 12'hABC;
      b     = 12'hABC;
      tick();
      start = 1'b0;
      chk_all("abc_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick(); chk("abc_c2.done", {11'd0, done}, 12'd0);
      tick(); chk("abc_c3.done", {11'd0, done}, 12'd0);
      tick(); chk("abc_c4.done", {11'd0, done}, 12'd0);
      tick(); chk_all("abc_c5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
      tick(); chk_all("abc_c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);

      // MSB slice differs: early exit after one slice; abort in DONE is ignored
      start = 1'b1;
      a     = 12'h800;
      b     = 12'h7FF;
      tick();
      start = 1'b0;
      chk_all("gt_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
      chk_all("gt_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_all("gt_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);

      // LSB slice decides; start and operand changes while busy are ignored
      start = 1'b1;
      a     = 12'h123;
      b     = 12'h124;
      tick();
      a = 12'h000;
      b = 12'h000;
      chk_all("lt_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick(); chk("lt_c2.done", {11'd0, done}, 12'd0);
      tick(); chk("lt_c3.done", {11'd0, done}, 12'd0);
      tick(); chk("lt_c4.done", {11'd0, done}, 12'd0);
      tick(); chk_all("lt_c5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
      tick();
      start = 1'b0;
      chk_all("lt_c6", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
      tick();
      chk_all("lt_c7", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);

      // abort in RUN during the second slice
      start = 1'b1;
      a     = 12'h040;
      b     = 12'h000;
      tick();
      start = 1'b0;
      chk_all("ab_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
      chk_all("ab_c2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_all("ab_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
      chk_all("ab_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      // start and abort together in IDLE: start wins; then reset mid-RUN
      start = 1'b1;
      abort = 1'b1;
      a     = 12'hFFF;
      b     = 12'hFFF;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_c1.busy", {11'd0, busy}, 12'd1);
      tick();
      chk("sa_c2.busy", {11'd0, busy}, 12'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
      chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      a     = 12'h001;
      b     = 12'h002;
      tick();
      start = 1'b0;
      chk_all("post_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick(); chk("post_c2.done", {11'd0, done}, 12'd0);
      tick(); chk("post_c3.done", {11'd0, done}, 12'd0);
      tick(); chk("post_c4.done", {11'd0, done}, 12'd0);
      tick(); chk_all("post_c5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
      tick(); chk_all("post_c6", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
